// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable, mux select and the ALUOp code for ALU control.
module mc_main_control #(
    parameter int unsigned ALUOP_W  = 4,
    parameter logic [5:0]  FUNCT_JR = 6'd8,
    parameter bit          WAIT_MEM = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ZeroExt,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               IllegalOp
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_ALUWB    = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMMWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JR       = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_ADDI  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLTI  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_ANDI  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_ORI   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(7);

    state_t state;
    state_t next_state;
    logic   mem_ready;

    assign mem_ready = WAIT_MEM ? MemReady : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ZeroExt     = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = ALU_ADD;
        IllegalOp   = 1'b0;

        case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end

            // PC and IR only load on the cycle the memory actually returns data
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_RTYPE:      next_state = (Funct == FUNCT_JR) ? S_JR : S_RTYPE_EX;
                    OP_BEQ:        next_state = S_BRANCH;
                    OP_J:          next_state = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:
                                   next_state = S_IMM_EX;
                    default:       next_state = S_ILLEGAL;
                endcase
            end

            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end
            end

            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                next_state = S_FETCH;
            end

            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end
            end

            S_RTYPE_EX: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALU_FUNCT;
                next_state = S_ALUWB;
            end

            S_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                next_state = S_FETCH;
            end

            S_IMM_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Op)
                    OP_SLTI: ALUOp = ALU_SLTI;
                    OP_ANDI: begin
                        ALUOp   = ALU_ANDI;
                        ZeroExt = 1'b1;
                    end
                    OP_ORI: begin
                        ALUOp   = ALU_ORI;
                        ZeroExt = 1'b1;
                    end
                    OP_LUI:  ALUOp = ALU_LUI;
                    default: ALUOp = ALU_ADDI;
                endcase
                next_state = S_IMMWB;
            end

            S_IMMWB: begin
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end

            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                next_state  = S_FETCH;
            end

            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                next_state = S_FETCH;
            end

            S_JR: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
                next_state = S_FETCH;
            end

            S_ILLEGAL: begin
                IllegalOp  = 1'b1;
                next_state = S_FETCH;
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: per-instruction expected output sequences
// are generated from the instruction class and compared every cycle.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ZeroExt, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp;

    mc_main_control #(
        .ALUOP_W (4),
        .FUNCT_JR(6'd8),
        .WAIT_MEM(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .Funct      (Funct),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ZeroExt    (ZeroExt),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .ALUOp      (ALUOp),
        .IllegalOp  (IllegalOp)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ZeroExt, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp};

    localparam logic [19:0] PCW  = 20'h80000;
    localparam logic [19:0] PCWC = 20'h40000;
    localparam logic [19:0] IORD = 20'h20000;
    localparam logic [19:0] MRD  = 20'h10000;
    localparam logic [19:0] MWR  = 20'h08000;
    localparam logic [19:0] IRW  = 20'h04000;
    localparam logic [19:0] M2R  = 20'h02000;
    localparam logic [19:0] RDST = 20'h01000;
    localparam logic [19:0] RW   = 20'h00800;
    localparam logic [19:0] ZEXT = 20'h00400;
    localparam logic [19:0] SRCA = 20'h00200;
    localparam logic [19:0] ILL  = 20'h00001;

    function automatic logic [19:0] srcb(input int v); return 20'(v) << 7; endfunction
    function automatic logic [19:0] pcs(input int v);  return 20'(v) << 5; endfunction
    function automatic logic [19:0] aop(input int v);  return 20'(v) << 1; endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        rdy;
        logic [19:0] exp;
    } step_t;

    step_t steps[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic push(input logic [5:0] op, input logic [5:0] funct,
                        input logic rdy, input logic [19:0] e);
        step_t s;
        s.op = op; s.funct = funct; s.rdy = rdy; s.exp = e;
        steps.push_back(s);
    endtask

    // Reference model: expands one instruction into its expected per-cycle outputs.
    task automatic gen_instr(input logic [5:0] op, input logic [5:0] funct,
                             input int fstall, input int mstall);
        logic [19:0] mem;
        int          a;
        logic        z;
        for (int i = 0; i < fstall; i++) push(6'($urandom), 6'($urandom), 1'b0, MRD | srcb(1));
        push(6'($urandom), 6'($urandom), 1'b1, MRD | IRW | PCW | srcb(1));
        push(op, funct, 1'($urandom), srcb(3));
        a = 3; z = 1'b0;
        case (op)
            6'h23, 6'h2B: begin
                mem = (op == 6'h23) ? (MRD | IORD) : (MWR | IORD);
                push(op, funct, 1'($urandom), SRCA | srcb(2));
                for (int i = 0; i < mstall; i++) push(op, funct, 1'b0, mem);
                push(op, funct, 1'b1, mem);
                if (op == 6'h23) push(op, funct, 1'($urandom), RW | M2R);
            end
            6'h00: begin
                if (funct == 6'd8) begin
                    push(op, funct, 1'($urandom), PCW | pcs(3));
                end else begin
                    push(op, funct, 1'($urandom), SRCA | aop(2));
                    push(op, funct, 1'($urandom), RW | RDST);
                end
            end
            6'h04: push(op, funct, 1'($urandom), SRCA | aop(1) | PCWC | pcs(1));
            6'h02: push(op, funct, 1'($urandom), PCW | pcs(2));
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
                if (op == 6'h0A) a = 4;
                if (op == 6'h0C) begin a = 5; z = 1'b1; end
                if (op == 6'h0D) begin a = 6; z = 1'b1; end
                if (op == 6'h0F) a = 7;
                push(op, funct, 1'($urandom), SRCA | srcb(2) | aop(a) | (z ? ZEXT : 20'h0));
                push(op, funct, 1'($urandom), RW);
            end
            default: push(op, funct, 1'($urandom), ILL);
        endcase
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (MemRead && MemWrite) begin
                failures++;
                $display("FAIL mem_exclusive MemRead=%b MemWrite=%b required not both 1", MemRead, MemWrite);
            end
        end
    end

    task automatic test_reset();
        step_t s;
        Op = '0; Funct = '0; MemReady = 1'b0; rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== 20'h0) begin failures++; $display("FAIL reset_hold obs=%05h exp=00000", obs); end
        rst_n = 1'b1; #1;
        checks++;
        if (obs !== 20'h0) begin failures++; $display("FAIL reset_idle obs=%05h exp=00000", obs); end
        @(posedge clk); #1;
        gen_instr(6'h2B, 6'($urandom), 0, 1);
        for (int n = 0; n < 4; n++) begin
            s = steps.pop_front();
            Op = s.op; Funct = s.funct; MemReady = s.rdy;
            #1;
            checks++;
            if (obs !== s.exp) begin failures++; $display("FAIL reset_sw step%0d obs=%05h exp=%05h", n, obs, s.exp); end
            if (n < 3) begin @(posedge clk); #1; end
        end
        steps.delete();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || obs !== 20'h0) begin
            failures++; $display("FAIL reset_mid_memwr obs=%05h MemWrite=%b exp=00000", obs, MemWrite);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        checks++;
        if (obs !== 20'h0) begin failures++; $display("FAIL reset_release_idle obs=%05h exp=00000", obs); end
        @(posedge clk); #1;
        MemReady = 1'b0; #1;
        checks++;
        if (obs !== (MRD | srcb(1))) begin
            failures++; $display("FAIL reset_then_fetch obs=%05h exp=%05h", obs, MRD | srcb(1));
        end
    endtask

    task automatic test_lw();
        step_t s;
        int n = 0;
        gen_instr(6'h23, 6'($urandom), 0, 0);
        while (steps.size() > 0) begin
            s = steps.pop_front();
            Op = s.op; Funct = s.funct; MemReady = s.rdy;
            #1;
            checks++;
            if (obs !== s.exp) begin failures++; $display("FAIL lw step%0d obs=%05h exp=%05h", n, obs, s.exp); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_stall();
        step_t s;
        int n = 0;
        gen_instr(6'h00, 6'h20, 3, 0);
        gen_instr(6'h23, 6'($urandom), 1, 2);
        gen_instr(6'h2B, 6'($urandom), 2, 3);
        while (steps.size() > 0) begin
            s = steps.pop_front();
            Op = s.op; Funct = s.funct; MemReady = s.rdy;
            #1;
            checks++;
            if (obs !== s.exp) begin failures++; $display("FAIL stall step%0d obs=%05h exp=%05h", n, obs, s.exp); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype_jr();
        step_t s;
        int n = 0;
        gen_instr(6'h00, 6'h20, 0, 0);
        gen_instr(6'h00, 6'h08, 0, 0);
        gen_instr(6'h04, 6'($urandom), 0, 0);
        gen_instr(6'h02, 6'($urandom), 0, 0);
        while (steps.size() > 0) begin
            s = steps.pop_front();
            Op = s.op; Funct = s.funct; MemReady = s.rdy;
            #1;
            checks++;
            if (obs !== s.exp) begin failures++; $display("FAIL rtype_jr step%0d obs=%05h exp=%05h", n, obs, s.exp); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_immediates();
        step_t s;
        int n = 0;
        gen_instr(6'h0C, 6'($urandom), 0, 0);
        gen_instr(6'h0F, 6'($urandom), 0, 0);
        gen_instr(6'h0A, 6'($urandom), 0, 0);
        gen_instr(6'h08, 6'($urandom), 0, 0);
        gen_instr(6'h0D, 6'($urandom), 0, 0);
        while (steps.size() > 0) begin
            s = steps.pop_front();
            Op = s.op; Funct = s.funct; MemReady = s.rdy;
            #1;
            checks++;
            if (obs !== s.exp) begin failures++; $display("FAIL imm step%0d obs=%05h exp=%05h", n, obs, s.exp); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        step_t s;
        int n = 0;
        gen_instr(6'h3F, 6'($urandom), 0, 0);
        gen_instr(6'h01, 6'($urandom), 0, 0);
        gen_instr(6'h23, 6'($urandom), 0, 0);
        while (steps.size() > 0) begin
            s = steps.pop_front();
            Op = s.op; Funct = s.funct; MemReady = s.rdy;
            #1;
            checks++;
            if (obs !== s.exp) begin failures++; $display("FAIL illegal step%0d obs=%05h exp=%05h", n, obs, s.exp); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t      s;
        int         n = 0;
        int         k;
        logic [5:0] ops [11];
        logic [5:0] op, funct;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 11);
            op = (k == 11) ? 6'($urandom) : ops[k];
            funct = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom);
            gen_instr(op, funct, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        while (steps.size() > 0) begin
            s = steps.pop_front();
            Op = s.op; Funct = s.funct; MemReady = s.rdy;
            #1;
            checks++;
            if (obs !== s.exp) begin
                failures++;
                $display("FAIL b2b step%0d op=%02h funct=%02h obs=%05h exp=%05h", n, s.op, s.funct, obs, s.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_fetch_stall();
        test_rtype_jr();
        test_immediates();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
